// File: rtl/riscy_pkg.sv
// Shared types and constants for the riscy32 execute-stage units.
package riscy_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } muldiv_state_t;

    localparam int          MULDIV_ITERS = 32;
    localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q    = 32'h8000_0000;

    // Divide family shares funct3[2] = 1
    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is treated as two's complement
    function automatic logic op_rs1_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as two's complement
    function automatic logic op_rs2_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    // Result comes from the low word of the fixed-up value
    function automatic logic op_low_result(input muldiv_op_t op);
        return (op == OP_MUL) || op[2];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used to take operand magnitudes
// and to restore the sign of the final product/quotient/remainder.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One CALC setup cycle takes operand
// magnitudes (or resolves divide special cases), then 32 radix-2 steps run
// on a shared 64-bit shift register and a 33-bit adder/subtractor.
module muldiv_unit
    import riscy_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd,
    output logic [1:0]      flags
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERS - 1);

    muldiv_state_t     state, state_next;
    muldiv_op_t        op_q;
    logic [XLEN-1:0]   a_q, b_q;       // raw operands as latched at start
    logic [XLEN-1:0]   b_mag_q;        // multiplicand / divisor magnitude
    logic [2*XLEN-1:0] sreg;           // {acc_hi, multiplier} or {rem, quo}
    logic [4:0]        cnt;
    logic              setup;          // first CALC cycle, no iteration yet

    logic              a_neg, b_neg, res_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     add_x, add_y, add_sum;
    logic              add_cin, add_cout;
    logic [2*XLEN-1:0] sreg_step;
    logic [2*XLEN-1:0] res_pre, res_fixed;
    logic [XLEN-1:0]   rd_calc, rd_special;
    logic [1:0]        flags_special;

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

    // Operand signs and magnitudes come from the latched registers, so the
    // live inputs have no influence once the operation is accepted.
    assign a_neg   = op_rs1_signed(op_q) & a_q[XLEN-1];
    assign b_neg   = op_rs2_signed(op_q) & b_q[XLEN-1];
    assign res_neg = op_is_rem(op_q) ? a_neg : (a_neg ^ b_neg);

    muldiv_signfix #(.W(XLEN)) u_fix_a (
        .value  (a_q),
        .negate (a_neg),
        .result (a_mag)
    );

    muldiv_signfix #(.W(XLEN)) u_fix_b (
        .value  (b_q),
        .negate (b_neg),
        .result (b_mag)
    );

    // Special cases bypass the iteration entirely
    assign div_zero = op_is_div(op_q) && (b_q == '0);
    assign div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                      (a_q == DIV_OVF_Q) && (b_q == '1);

    // Special-case result and flags
    always_comb begin
        rd_special    = '0;
        flags_special = 2'b00;
        if (div_zero) begin
            rd_special    = op_is_rem(op_q) ? a_q : DIV_ZERO_Q;
            flags_special = 2'b01;
        end else if (div_ovf) begin
            rd_special    = op_is_rem(op_q) ? '0 : DIV_OVF_Q;
            flags_special = 2'b10;
        end
    end

    // Shared adder: accumulate for multiply, trial-subtract for divide
    always_comb begin
        if (op_is_div(op_q)) begin
            add_x   = sreg[2*XLEN-1:XLEN-1];
            add_y   = ~{1'b0, b_mag_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, sreg[2*XLEN-1:XLEN]};
            add_y   = sreg[0] ? {1'b0, b_mag_q} : '0;
            add_cin = 1'b0;
        end
        {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};
    end

    // One radix-2 step; a divide carry-out means the trial subtract fit
    always_comb begin
        if (op_is_div(op_q)) begin
            sreg_step = add_cout ? {add_sum[XLEN-1:0], sreg[XLEN-2:0], 1'b1}
                                 : {sreg[2*XLEN-2:0], 1'b0};
        end else begin
            sreg_step = {add_sum, sreg[XLEN-1:1]};
        end
    end

    // Select quotient/remainder or full product before the sign fixup so
    // that the high product word is taken from the negated 64-bit value.
    always_comb begin
        if (op_is_div(op_q)) begin
            res_pre = {{XLEN{1'b0}},
                       op_is_rem(op_q) ? sreg_step[2*XLEN-1:XLEN] : sreg_step[XLEN-1:0]};
        end else begin
            res_pre = sreg_step;
        end
    end

    muldiv_signfix #(.W(2*XLEN)) u_fix_res (
        .value  (res_pre),
        .negate (res_neg),
        .result (res_fixed)
    );

    assign rd_calc = op_low_result(op_q) ? res_fixed[XLEN-1:0]
                                         : res_fixed[2*XLEN-1:XLEN];

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: begin
                if (setup) begin
                    if (div_zero || div_ovf) state_next = ST_DONE;
                end else if (cnt == LAST_ITER) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = start ? ST_CALC : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            b_mag_q <= '0;
            sreg    <= '0;
            cnt     <= '0;
            setup   <= 1'b0;
            rd      <= '0;
            flags   <= 2'b00;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_q  <= muldiv_op_t'(op);
                        a_q   <= rs1;
                        b_q   <= rs2;
                        cnt   <= '0;
                        setup <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (setup) begin
                        setup   <= 1'b0;
                        cnt     <= '0;
                        sreg    <= {{XLEN{1'b0}}, a_mag};
                        b_mag_q <= b_mag;
                        if (div_zero || div_ovf) begin
                            rd    <= rd_special;
                            flags <= flags_special;
                        end
                    end else begin
                        sreg <= sreg_step;
                        cnt  <= cnt + 5'd1;
                        if (cnt == LAST_ITER) begin
                            rd    <= rd_calc;
                            flags <= 2'b00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int MAX_WAIT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op_in = 3'b000;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, done;
    logic [31:0] rd;
    logic [1:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op_in),
        .rs1   (rs1),
        .rs2   (rs2),
        .busy  (busy),
        .done  (done),
        .rd    (rd),
        .flags (flags)
    );

    always #5 clk = ~clk;

    // Issue one operation; lat counts edges after the accepting edge until
    // done is seen (MAX_WAIT on timeout), bcnt counts cycles busy was high.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [1:0] f,
                          output int lat, output int bcnt);
        logic got;
        @(negedge clk);
        start = 1'b1; op_in = o; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; op_in = ~o;
        bcnt = busy ? 1 : 0;
        lat  = 0;
        got  = 1'b0;
        while (!got && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
            got = done;
            if (!got && busy) bcnt++;
        end
        r = rd;
        f = flags;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_rd: got %h expected 00000000", rd); else n_pass++;
        n_checks++; if (flags !== 2'b00) $display("FAIL reset_flags: got %b expected 00", flags); else n_pass++;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [6] = '{MUL, MUL, MULH, MULHU, MULHSU, MULH};
        logic [31:0] av  [6] = '{32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bv  [6] = '{32'd30, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,         32'h8000_0000};
        logic [31:0] ev  [6] = '{32'd600, 32'hFFFF_FFF1, 32'h0,        32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] r;
        logic [1:0]  f;
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], av[i], bv[i], r, f, lat, bcnt);
            n_checks++; if (r !== ev[i]) $display("FAIL mul_rd[%0d]: got %h expected %h", i, r, ev[i]); else n_pass++;
            n_checks++; if (lat !== 33) $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); else n_pass++;
            n_checks++; if (f !== 2'b00) $display("FAIL mul_flags[%0d]: got %b expected 00", i, f); else n_pass++;
            if (i == 0) begin
                n_checks++; if (bcnt !== 33) $display("FAIL mul_busy_cycles: got %0d expected 33", bcnt); else n_pass++;
                @(posedge clk); #1;
                n_checks++; if (done !== 1'b0) $display("FAIL mul_done_pulse: got %b expected 0", done); else n_pass++;
                n_checks++; if (rd !== 32'd600) $display("FAIL mul_rd_hold: got %h expected %h", rd, 32'd600); else n_pass++;
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [6] = '{DIV, REM, DIVU, REMU, DIV, REM};
        logic [31:0] av  [6] = '{32'd5, 32'd5, 32'd5, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [6] = '{32'd0, 32'd0, 32'd0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev  [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0};
        logic [1:0]  efv [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        logic [31:0] r;
        logic [1:0]  f;
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], av[i], bv[i], r, f, lat, bcnt);
            n_checks++; if (r !== ev[i]) $display("FAIL special_rd[%0d]: got %h expected %h", i, r, ev[i]); else n_pass++;
            n_checks++; if (f !== efv[i]) $display("FAIL special_flags[%0d]: got %b expected %b", i, f, efv[i]); else n_pass++;
            n_checks++; if (lat !== 1) $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); else n_pass++;
            n_checks++; if (bcnt !== 1) $display("FAIL special_busy_cycles[%0d]: got %0d expected 1", i, bcnt); else n_pass++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [8] = '{DIV, REM, DIVU, REMU, DIV, REM, DIVU, REMU};
        logic [31:0] av  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd8, 32'd8, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd3, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFD, 32'd1, 32'h0, 32'h8000_0000};
        logic [31:0] r;
        logic [1:0]  f;
        int lat, bcnt;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], av[i], bv[i], r, f, lat, bcnt);
            n_checks++; if (r !== ev[i]) $display("FAIL div_rd[%0d]: got %h expected %h", i, r, ev[i]); else n_pass++;
            n_checks++; if (lat !== 33) $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); else n_pass++;
            n_checks++; if (f !== 2'b00) $display("FAIL div_flags[%0d]: got %b expected 00", i, f); else n_pass++;
        end
    endtask

    task automatic test_start_in_calc();
        int lat = 0;
        logic got = 1'b0;
        @(negedge clk);
        start = 1'b1; op_in = MUL; rs1 = 32'd20; rs2 = 32'd30;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
            got = done;
            if (lat == 5) begin
                start = 1'b1; op_in = DIVU; rs1 = 32'd99; rs2 = 32'd5;
            end
            if (lat == 9) start = 1'b0;
        end
        start = 1'b0;
        n_checks++; if (lat !== 33) $display("FAIL calc_ignore_latency: got %0d expected 33", lat); else n_pass++;
        n_checks++; if (rd !== 32'd600) $display("FAIL calc_ignore_rd: got %h expected %h", rd, 32'd600); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL calc_ignore_idle: got busy=%b done=%b expected busy=0 done=0", busy, done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [1:0]  f;
        int lat, bcnt;
        logic got = 1'b0;
        run_op(MUL, 32'd6, 32'd7, r, f, lat, bcnt);
        n_checks++; if (r !== 32'd42) $display("FAIL b2b_first_rd: got %h expected %h", r, 32'd42); else n_pass++;
        // Still inside the done cycle: request the next operation now
        start = 1'b1; op_in = DIVU; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_rise: got %b expected 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_low: got %b expected 0", done); else n_pass++;
        n_checks++; if (rd !== 32'd42) $display("FAIL b2b_rd_hold: got %h expected %h", rd, 32'd42); else n_pass++;
        lat = 0;
        while (!got && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
            got = done;
        end
        n_checks++; if (lat !== 33) $display("FAIL b2b_latency: got %0d expected 33", lat); else n_pass++;
        n_checks++; if (rd !== 32'd14) $display("FAIL b2b_second_rd: got %h expected %h", rd, 32'd14); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [1:0]  f;
        int lat, bcnt;
        int done_seen = 0;
        @(negedge clk);
        start = 1'b1; op_in = MUL; rs1 = 32'd9; rs2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL midrst_rd: got %h expected 00000000", rd); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done); else n_pass++;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        n_checks++; if (done_seen !== 0) $display("FAIL midrst_no_done: got %0d done cycles expected 0", done_seen); else n_pass++;
        run_op(MUL, 32'd3, 32'd4, r, f, lat, bcnt);
        n_checks++; if (r !== 32'd12) $display("FAIL midrst_next_rd: got %h expected %h", r, 32'd12); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL midrst_next_latency: got %0d expected 33", lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_special();
        test_div();
        test_start_in_calc();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
